// File: rtl/irq_ctrl.sv
// Platform interrupt controller: synchronises NSRC device lines, tracks pending/in-service
// state per source and offers a claim/complete register port driving a single irq line.
module irq_ctrl #(
   parameter int NSRC = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NSRC-1:0] src,
   input  logic            req,
   input  logic            we,
   input  logic [2:0]      addr,
   input  logic [31:0]     wdata,
   output logic [31:0]     rdata,
   output logic            ack,
   output logic            irq
);

   localparam logic [2:0] A_PEND  = 3'd0;
   localparam logic [2:0] A_EN    = 3'd1;
   localparam logic [2:0] A_EDGE  = 3'd2;
   localparam logic [2:0] A_CLAIM = 3'd3;
   localparam logic [2:0] A_INSVC = 3'd4;

   logic [NSRC-1:0] sync1_r, sync2_r, sync3_r;
   logic [NSRC-1:0] pending_r, enable_r, edge_r, in_service_r;
   logic [31:0]     rdata_r;
   logic            ack_r, irq_r;

   logic [NSRC-1:0] claimable_s, edge_set_s, w1c_s, edge_off_s;
   logic [NSRC-1:0] claim_mask_s, complete_mask_s, pending_nxt_s, in_service_nxt_s;
   logic [4:0]      claim_id_s;
   logic            wr_s, rd_s, claim_rd_s;
   logic [31:0]     rd_mux_s;

   // Lowest claimable index wins; result is index+1, or 0 when nothing is claimable.
   function automatic logic [4:0] first_id(input logic [NSRC-1:0] v);
      logic [4:0] id;
      id = 5'd0;
      for (int i = 0; i < NSRC; i++) begin
         if (v[i] && (id == 5'd0)) begin
            id = 5'(i + 1);
         end else begin
            id = id;
         end
      end
      return id;
   endfunction

   // Next-state decode for pending/in-service and the read mux.
   always_comb begin
      wr_s        = req & we;
      rd_s        = req & ~we;
      claimable_s = pending_r & enable_r & ~in_service_r;
      claim_id_s  = first_id(claimable_s);
      claim_rd_s  = rd_s && (addr == A_CLAIM) && (claim_id_s != 5'd0);
      edge_set_s  = sync2_r & ~sync3_r & edge_r;
      w1c_s       = {NSRC{1'b0}};
      edge_off_s  = {NSRC{1'b0}};
      if (wr_s && (addr == A_PEND)) begin
         w1c_s = wdata[NSRC-1:0] & edge_r;
      end else begin
         w1c_s = {NSRC{1'b0}};
      end
      if (wr_s && (addr == A_EDGE)) begin
         edge_off_s = edge_r & ~wdata[NSRC-1:0];
      end else begin
         edge_off_s = {NSRC{1'b0}};
      end
      for (int i = 0; i < NSRC; i++) begin
         claim_mask_s[i]    = claim_rd_s && (claim_id_s == 5'(i + 1));
         complete_mask_s[i] = wr_s && (addr == A_CLAIM) && (wdata == 32'(i + 1));
      end
      // Hardware edge set beats both W1C and the claim-side clear.
      pending_nxt_s    = (edge_r & (((pending_r & ~w1c_s & ~claim_mask_s) | edge_set_s) & ~edge_off_s))
                       | (~edge_r & sync2_r);
      in_service_nxt_s = (in_service_r | claim_mask_s) & ~complete_mask_s;
      case (addr)
         A_PEND:  rd_mux_s = {{(32-NSRC){1'b0}}, pending_r};
         A_EN:    rd_mux_s = {{(32-NSRC){1'b0}}, enable_r};
         A_EDGE:  rd_mux_s = {{(32-NSRC){1'b0}}, edge_r};
         A_CLAIM: rd_mux_s = {27'd0, claim_id_s};
         A_INSVC: rd_mux_s = {{(32-NSRC){1'b0}}, in_service_r};
         default: rd_mux_s = 32'd0;
      endcase
   end

   // State, synchroniser and registered bus/irq outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_r      <= {NSRC{1'b0}};
         sync2_r      <= {NSRC{1'b0}};
         sync3_r      <= {NSRC{1'b0}};
         pending_r    <= {NSRC{1'b0}};
         enable_r     <= {NSRC{1'b0}};
         edge_r       <= {NSRC{1'b0}};
         in_service_r <= {NSRC{1'b0}};
         rdata_r      <= 32'd0;
         ack_r        <= 1'b0;
         irq_r        <= 1'b0;
      end else begin
         sync1_r      <= src;
         sync2_r      <= sync1_r;
         sync3_r      <= sync2_r;
         pending_r    <= pending_nxt_s;
         in_service_r <= in_service_nxt_s;
         irq_r        <= |claimable_s;
         ack_r        <= req;
         if (wr_s && (addr == A_EN)) begin
            enable_r <= wdata[NSRC-1:0];
         end else begin
            enable_r <= enable_r;
         end
         if (wr_s && (addr == A_EDGE)) begin
            edge_r <= wdata[NSRC-1:0];
         end else begin
            edge_r <= edge_r;
         end
         if (rd_s) begin
            rdata_r <= rd_mux_s;
         end else begin
            rdata_r <= 32'd0;
         end
      end
   end

   assign rdata = rdata_r;
   assign ack   = ack_r;
   assign irq   = irq_r;

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: accesses push expected read data, a negedge monitor
// pops on every ack and compares; irq is checked directly at chosen points.
module tb_irq_ctrl;

   localparam int NSRC = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic [NSRC-1:0] src;
   logic            req, we;
   logic [2:0]      addr;
   logic [31:0]     wdata;
   logic [31:0]     rdata;
   logic            ack, irq;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_q[$];
   bit          chk_q[$];
   string       name_q[$];

   irq_ctrl #(.NSRC(NSRC)) dut (
      .clk(clk), .rst(rst), .src(src), .req(req), .we(we), .addr(addr),
      .wdata(wdata), .rdata(rdata), .ack(ack), .irq(irq)
   );

   always #5 clk = ~clk;

   // Monitor: every ack must match one queued access, in order.
   always @(negedge clk) begin
      if (rst && ack) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack: ack=1 with no outstanding access");
         end else begin
            logic [31:0] e;
            bit          c;
            string       n;
            e = exp_q.pop_front();
            c = chk_q.pop_front();
            n = name_q.pop_front();
            if (c) begin
               checks++;
               if (rdata !== e) begin
                  errors++;
                  $display("FAIL %s: rdata=0x%08h expected 0x%08h", n, rdata, e);
               end
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus(input logic w, input logic [2:0] a, input logic [31:0] d,
                      input logic [31:0] e, input string n);
      req = 1'b1; we = w; addr = a; wdata = d;
      exp_q.push_back(e);
      chk_q.push_back(!w);
      name_q.push_back(n);
      @(posedge clk);
      #1;
      req = 1'b0; we = 1'b0;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      bus(1'b1, a, d, 32'd0, "write");
   endtask

   task automatic rd(input logic [2:0] a, input logic [31:0] e, input string n);
      bus(1'b0, a, 32'd0, e, n);
   endtask

   task automatic chk_irq(input logic e, input string n);
      checks++;
      if (irq !== e) begin
         errors++;
         $display("FAIL %s: irq=%0b expected %0b", n, irq, e);
      end
   endtask

   initial begin
      src = '0; req = 1'b0; we = 1'b0; addr = 3'd0; wdata = 32'd0;
      rst = 1'b1;
      #1 rst = 1'b0;
      #2;
      chk_irq(1'b0, "reset_irq");
      checks++;
      if (ack !== 1'b0 || rdata !== 32'd0) begin
         errors++;
         $display("FAIL reset_bus: ack=%0b rdata=0x%08h expected ack=0 rdata=0", ack, rdata);
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      rd(3'd1, 32'd0, "reset_enable");
      rd(3'd0, 32'd0, "reset_pending");
      rd(3'd3, 32'd0, "reset_claim");
      rd(3'd4, 32'd0, "reset_insvc");

      // Edge source 0: four-edge latency, claim, complete
      wr(3'd2, 32'h01);
      wr(3'd1, 32'h01);
      src = 8'h01; tick(1); src = 8'h00; tick(2);
      chk_irq(1'b0, "edge0_irq_3rd_edge");
      tick(1);
      chk_irq(1'b1, "edge0_irq_4th_edge");
      rd(3'd3, 32'd1, "edge0_claim");
      chk_irq(1'b1, "edge0_irq_at_claim");
      rd(3'd0, 32'd0, "edge0_pending_after_claim");
      chk_irq(1'b0, "edge0_irq_after_claim");
      rd(3'd4, 32'h01, "edge0_insvc");
      wr(3'd3, 32'd1);
      rd(3'd4, 32'h00, "edge0_insvc_after_complete");

      // Level source 3 held high
      wr(3'd2, 32'h00);
      wr(3'd1, 32'h08);
      src = 8'h08; tick(4);
      chk_irq(1'b1, "lvl3_irq");
      rd(3'd3, 32'd4, "lvl3_claim");
      tick(1);
      chk_irq(1'b0, "lvl3_irq_after_claim");
      wr(3'd3, 32'd4);
      tick(1);
      chk_irq(1'b1, "lvl3_irq_reassert");
      rd(3'd3, 32'd4, "lvl3_claim_again");
      src = 8'h00; tick(1);
      rd(3'd0, 32'h08, "lvl3_pending_1");
      rd(3'd0, 32'h08, "lvl3_pending_2");
      rd(3'd0, 32'h00, "lvl3_pending_cleared");
      wr(3'd3, 32'd4);

      // Two edge sources: priority order then empty claim
      wr(3'd2, 32'h24);
      wr(3'd1, 32'h24);
      src = 8'h24; tick(1); src = 8'h00; tick(5);
      chk_irq(1'b1, "dual_irq");
      rd(3'd3, 32'd3, "dual_claim_first");
      rd(3'd3, 32'd6, "dual_claim_second");
      tick(2);
      chk_irq(1'b0, "dual_irq_drained");
      rd(3'd3, 32'd0, "dual_claim_none");
      rd(3'd4, 32'h24, "dual_insvc");
      rd(3'd0, 32'h00, "dual_pending");
      wr(3'd3, 32'd3);
      wr(3'd3, 32'd6);
      rd(3'd4, 32'h00, "dual_insvc_cleared");

      // Edge source 1 re-pended while in service
      wr(3'd2, 32'h02);
      wr(3'd1, 32'h02);
      src = 8'h02; tick(1); src = 8'h00; tick(4);
      chk_irq(1'b1, "rearm_irq");
      rd(3'd3, 32'd2, "rearm_claim");
      tick(2);
      chk_irq(1'b0, "rearm_irq_after_claim");
      src = 8'h02; tick(1); src = 8'h00; tick(4);
      rd(3'd0, 32'h02, "rearm_pending_in_service");
      chk_irq(1'b0, "rearm_irq_blocked");
      wr(3'd3, 32'd2);
      tick(1);
      chk_irq(1'b1, "rearm_irq_after_complete");
      rd(3'd3, 32'd2, "rearm_claim_again");
      wr(3'd3, 32'd2);

      // W1C racing a hardware edge; level bit ignores W1C
      wr(3'd2, 32'h01);
      wr(3'd1, 32'h00);
      src = 8'h10; tick(3);
      src = 8'h11; tick(1); src = 8'h10; tick(1);
      wr(3'd0, 32'hFF);
      rd(3'd0, 32'h11, "w1c_set_wins");
      wr(3'd0, 32'hFF);
      rd(3'd0, 32'h10, "w1c_clears_edge_only");

      // Out-of-range completes and reserved addresses
      wr(3'd1, 32'h10);
      rd(3'd3, 32'd5, "lvl4_claim");
      rd(3'd4, 32'h10, "lvl4_insvc");
      wr(3'd3, 32'd0);
      wr(3'd3, 32'd9);
      rd(3'd4, 32'h10, "bad_complete_insvc");
      rd(3'd1, 32'h10, "bad_complete_enable");
      rd(3'd5, 32'd0, "reserved_read");
      wr(3'd6, 32'hFFFF_FFFF);
      rd(3'd2, 32'h01, "reserved_write_edge");
      wr(3'd3, 32'd5);
      rd(3'd4, 32'h00, "lvl4_insvc_cleared");

      tick(2);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL ack_drain: outstanding=%0d expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
